// File: rtl/cmd_responder.sv
// Command responder: accepts command words, runs gyro calibration or a heading-then-move
// sequence with a speed ramp. Define CMD_RESP_FANFARE_EN to enable the fanfare pulse on opcode 4'b0101.
module cmd_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  input  logic        cal_done,
  output logic        strt_cal,
  output logic [11:0] desired_heading,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        fanfare
);

  typedef enum logic [2:0] {IDLE, CAL, HEADING, RAMP_UP, RAMP_DOWN} state_t;

  localparam logic [3:0]         OP_CAL     = 4'b0010;
  localparam logic [3:0]         OP_MOVE    = 4'b0100;
  localparam logic [3:0]         OP_MOVE_FF = 4'b0101;
  localparam logic [9:0]         FRWRD_MAX  = 10'h2A0;
  localparam logic [9:0]         UP_STEP    = 10'h010;
  localparam logic [9:0]         DOWN_STEP  = 10'h020;
  localparam logic signed [11:0] HDG_TOL    = 12'sh030;

  state_t      state, state_n;
  logic [9:0]  frwrd_n;
  logic [11:0] desired_heading_n;
  logic [3:0]  squares, squares_n;
  logic [4:0]  line_cnt, line_cnt_n;
  logic        cntr_q;
  logic        resp_pend, resp_pend_n;
  logic        clr_n, send_n, strt_n;
  logic        take_cmd;
  logic        line_edge;
  logic        hdg_ok;
  logic [4:0]  target;
  logic signed [11:0] hdg_err;

  // A new command is only taken once the previous acknowledge and response have cleared,
  // so clr_cmd_rdy and send_resp can never overlap.
  assign take_cmd  = (state == IDLE) && cmd_rdy && !clr_cmd_rdy && !send_resp && !resp_pend;
  assign line_edge = cntrIR & ~cntr_q;
  assign hdg_err   = heading - desired_heading;
  assign hdg_ok    = (hdg_err < HDG_TOL) && (hdg_err > -HDG_TOL);
  assign target    = {squares, 1'b0};
  assign moving    = (state == HEADING) || (state == RAMP_UP) || (state == RAMP_DOWN);

  always_comb begin
    state_n           = state;
    frwrd_n           = frwrd;
    desired_heading_n = desired_heading;
    squares_n         = squares;
    line_cnt_n        = line_cnt;
    resp_pend_n       = 1'b0;
    clr_n             = 1'b0;
    send_n            = 1'b0;
    strt_n            = 1'b0;

    if (line_edge && (state == HEADING || state == RAMP_UP) && line_cnt != 5'h1F)
      line_cnt_n = line_cnt + 5'd1;

    case (state)
      IDLE: begin
        send_n = resp_pend;
        if (take_cmd) begin
          clr_n      = 1'b1;
          line_cnt_n = '0;
          case (cmd[15:12])
            OP_CAL: begin
              strt_n  = 1'b1;
              state_n = CAL;
            end
            OP_MOVE, OP_MOVE_FF: begin
              squares_n         = cmd[3:0];
              desired_heading_n = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
              state_n           = HEADING;
            end
            default: resp_pend_n = 1'b1;
          endcase
        end
      end
      CAL: begin
        if (cal_done) begin
          send_n  = 1'b1;
          state_n = IDLE;
        end
      end
      HEADING: begin
        frwrd_n = '0;
        if (heading_rdy && hdg_ok) begin
          if (squares == 4'h0) begin
            send_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = RAMP_UP;
          end
        end
      end
      RAMP_UP: begin
        if (line_cnt_n >= target)
          state_n = RAMP_DOWN;
        else if (heading_rdy)
          frwrd_n = (frwrd >= FRWRD_MAX - UP_STEP) ? FRWRD_MAX : frwrd + UP_STEP;
      end
      RAMP_DOWN: begin
        if (frwrd == 10'h000) begin
          send_n  = 1'b1;
          state_n = IDLE;
        end else if (heading_rdy) begin
          frwrd_n = (frwrd > DOWN_STEP) ? frwrd - DOWN_STEP : 10'h000;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      frwrd           <= '0;
      desired_heading <= '0;
      squares         <= '0;
      line_cnt        <= '0;
      cntr_q          <= 1'b0;
      resp_pend       <= 1'b0;
      clr_cmd_rdy     <= 1'b0;
      send_resp       <= 1'b0;
      strt_cal        <= 1'b0;
    end else begin
      state           <= state_n;
      frwrd           <= frwrd_n;
      desired_heading <= desired_heading_n;
      squares         <= squares_n;
      line_cnt        <= line_cnt_n;
      cntr_q          <= cntrIR;
      resp_pend       <= resp_pend_n;
      clr_cmd_rdy     <= clr_n;
      send_resp       <= send_n;
      strt_cal        <= strt_n;
    end
  end

`ifdef CMD_RESP_FANFARE_EN
  logic fan_flag;
  logic fanfare_q;

  // The flag is re-latched on every accepted command, so only a 4'b0101 move can fire it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fan_flag  <= 1'b0;
      fanfare_q <= 1'b0;
    end else begin
      if (take_cmd)
        fan_flag <= (cmd[15:12] == OP_MOVE_FF);
      fanfare_q <= send_n & fan_flag;
    end
  end

  assign fanfare = fanfare_q;
`else
  assign fanfare = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_responder.sv
// Self-checking bench for cmd_responder: randomized heading noise, gaps and opcodes
// checked against expected speeds computed from the ramp arithmetic.
module tb_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = '0;
  logic        cmd_rdy = 1'b0;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [11:0] heading = '0;
  logic        heading_rdy = 1'b0;
  logic        cntrIR = 1'b0;
  logic        cal_done = 1'b0;
  logic        strt_cal;
  logic [11:0] desired_heading;
  logic [9:0]  frwrd;
  logic        moving;
  logic        fanfare;

  int tests_run = 0;
  int tests_failed = 0;
  int ack_count = 0;
  int overlap_count = 0;

`ifdef CMD_RESP_FANFARE_EN
  localparam logic FANFARE_ON = 1'b1;
`else
  localparam logic FANFARE_ON = 1'b0;
`endif

  cmd_responder dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .heading(heading), .heading_rdy(heading_rdy), .cntrIR(cntrIR),
    .cal_done(cal_done), .strt_cal(strt_cal), .desired_heading(desired_heading),
    .frwrd(frwrd), .moving(moving), .fanfare(fanfare)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_cmd_rdy) ack_count++;
    if (clr_cmd_rdy && send_resp) overlap_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic hdg_pulse(input logic [11:0] h);
    heading = h;
    heading_rdy = 1'b1;
    tick();
    heading_rdy = 1'b0;
  endtask

  task automatic ir_edge();
    cntrIR = 1'b1;
    tick();
    tick();
    cntrIR = 1'b0;
    tick();
    tick();
  endtask

  task automatic issue_cmd(input logic [15:0] c, output bit acked);
    cmd = c;
    cmd_rdy = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (clr_cmd_rdy) begin
        acked = 1'b1;
        break;
      end
    end
    cmd_rdy = 1'b0;
  endtask

  function automatic logic [11:0] near(input logic [11:0] d);
    int off;
    logic [11:0] o12;
    off = int'($urandom_range(0, 94)) - 47;
    o12 = off[11:0];
    return d + o12;
  endfunction

  function automatic int ramp_up_exp(input int k);
    return (16 * k > 672) ? 672 : 16 * k;
  endfunction

  function automatic int ramp_down_exp(input int start, input int j);
    return (start - 32 * j < 0) ? 0 : start - 32 * j;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    cmd = 16'h9000;
    cmd_rdy = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({clr_cmd_rdy, send_resp, strt_cal, moving, fanfare} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pulses: got %b expected 00000", {clr_cmd_rdy, send_resp, strt_cal, moving, fanfare});
    end
    tests_run++;
    if (frwrd !== 10'h000 || desired_heading !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: got frwrd=%0h dh=%0h expected 0 0", frwrd, desired_heading);
    end
    rst_n = 1'b1;
    #2;
    tests_run++;
    if (clr_cmd_rdy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ack_before_edge: got %b expected 0", clr_cmd_rdy);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (clr_cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ack_first_edge: got %b expected 1", clr_cmd_rdy);
    end
    cmd_rdy = 1'b0;
    tick();
    tests_run++;
    if ({clr_cmd_rdy, send_resp} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL resp_after_ack: got %b expected 01", {clr_cmd_rdy, send_resp});
    end
    tick();
  endtask

  task automatic test_cal();
    bit ok;
    int early;
    issue_cmd(16'h2000, ok);
    tests_run++;
    if (!ok || strt_cal !== 1'b1 || moving !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cal_start: got ack=%0d strt_cal=%b moving=%b expected 1 1 0", ok, strt_cal, moving);
    end
    tick();
    tests_run++;
    if ({strt_cal, clr_cmd_rdy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL cal_one_shot: got %b expected 00", {strt_cal, clr_cmd_rdy});
    end
    early = 0;
    repeat ($urandom_range(2, 10)) begin
      tick();
      if (send_resp) early++;
    end
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("[TB] FAIL cal_wait: got %0d early responses expected 0", early);
    end
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    tests_run++;
    if (send_resp !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL cal_resp: got %b expected 1", send_resp);
    end
    tick();
    tests_run++;
    if (send_resp !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cal_resp_one_cycle: got %b expected 0", send_resp);
    end
  endtask

  // Waits for the completion response and checks speed and fanfare at that cycle.
  task automatic finish_move(input string name, input logic exp_fan);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (send_resp) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!seen || frwrd !== 10'h000 || fanfare !== exp_fan) begin
      tests_failed++;
      $display("[TB] FAIL %s_done: got resp=%0d frwrd=%0h fanfare=%b expected 1 0 %b", name, seen, frwrd, fanfare, exp_fan);
    end
    tick();
    tests_run++;
    if ({send_resp, fanfare, moving} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL %s_idle: got %b expected 000", name, {send_resp, fanfare, moving});
    end
  endtask

  task automatic test_move_basic();
    bit ok;
    issue_cmd(16'h4002, ok);
    tests_run++;
    if (!ok || desired_heading !== 12'h000 || moving !== 1'b1 || frwrd !== 10'h000) begin
      tests_failed++;
      $display("[TB] FAIL move_accept: got ack=%0d dh=%0h moving=%b frwrd=%0h expected 1 0 1 0", ok, desired_heading, moving, frwrd);
    end
    hdg_pulse(12'h100);
    hdg_pulse(near(12'h000));
    tests_run++;
    if (frwrd !== 10'h000 || moving !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL move_heading: got frwrd=%0h moving=%b expected 0 1", frwrd, moving);
    end
    for (int k = 1; k <= 45; k++) begin
      gap();
      hdg_pulse(near(12'h000));
      tests_run++;
      if (int'(frwrd) != ramp_up_exp(k)) begin
        tests_failed++;
        $display("[TB] FAIL ramp_up_%0d: got %0h expected %0h", k, frwrd, ramp_up_exp(k));
      end
    end
    ir_edge();
    ir_edge();
    hdg_pulse(near(12'h000));
    tests_run++;
    if (frwrd !== 10'h2A0 || moving !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ramp_saturate: got frwrd=%0h moving=%b expected 2a0 1", frwrd, moving);
    end
    ir_edge();
    ir_edge();
    for (int j = 1; j <= 21; j++) begin
      gap();
      hdg_pulse(12'($urandom));
      tests_run++;
      if (int'(frwrd) != ramp_down_exp(672, j) || send_resp !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ramp_down_%0d: got frwrd=%0h resp=%b expected %0h 0", j, frwrd, send_resp, ramp_down_exp(672, j));
      end
    end
    finish_move("move_basic", 1'b0);
  endtask

  task automatic test_reset_midmove();
    bit ok;
    issue_cmd(16'h4003, ok);
    hdg_pulse(near(12'h000));
    for (int k = 1; k <= 16; k++) hdg_pulse(near(12'h000));
    tests_run++;
    if (!ok || frwrd !== 10'h100) begin
      tests_failed++;
      $display("[TB] FAIL midmove_speed: got ack=%0d frwrd=%0h expected 1 100", ok, frwrd);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (frwrd !== 10'h000 || moving !== 1'b0 || desired_heading !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL midmove_reset: got frwrd=%0h moving=%b dh=%0h expected 0 0 0", frwrd, moving, desired_heading);
    end
    tick();
    rst_n = 1'b1;
    tick();
    hdg_pulse(near(12'h000));
    hdg_pulse(near(12'h000));
    tests_run++;
    if (frwrd !== 10'h000 || moving !== 1'b0 || clr_cmd_rdy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midmove_idle: got frwrd=%0h moving=%b ack=%b expected 0 0 0", frwrd, moving, clr_cmd_rdy);
    end
  endtask

  task automatic test_move_fanfare();
    bit ok;
    int n;
    int off;
    logic [11:0] o12;
    int offs[5];
    issue_cmd(16'h57F1, ok);
    tests_run++;
    if (!ok || desired_heading !== 12'h7FF) begin
      tests_failed++;
      $display("[TB] FAIL fan_accept: got ack=%0d dh=%0h expected 1 7ff", ok, desired_heading);
    end
    offs[0] = -1023;
    offs[1] = 48;
    offs[2] = -48;
    for (int i = 3; i < 5; i++) begin
      off = int'($urandom_range(48, 2047));
      offs[i] = $urandom_range(0, 1) ? off : -off;
    end
    for (int i = 0; i < 5; i++) begin
      o12 = offs[i][11:0];
      hdg_pulse(12'h7FF + o12);
      tests_run++;
      if (frwrd !== 10'h000 || moving !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL fan_off_heading_%0d: got frwrd=%0h moving=%b expected 0 1", offs[i], frwrd, moving);
      end
    end
    hdg_pulse(12'h7FF + 12'h02F);
    tests_run++;
    if (frwrd !== 10'h000) begin
      tests_failed++;
      $display("[TB] FAIL fan_enter_ramp: got %0h expected 0", frwrd);
    end
    n = $urandom_range(3, 10);
    for (int k = 1; k <= n; k++) begin
      gap();
      hdg_pulse(near(12'h7FF));
      tests_run++;
      if (int'(frwrd) != ramp_up_exp(k)) begin
        tests_failed++;
        $display("[TB] FAIL fan_up_%0d: got %0h expected %0h", k, frwrd, ramp_up_exp(k));
      end
    end
    ir_edge();
    ir_edge();
    for (int j = 1; j <= (n + 1) / 2; j++) begin
      gap();
      hdg_pulse(near(12'h7FF));
      tests_run++;
      if (int'(frwrd) != ramp_down_exp(16 * n, j)) begin
        tests_failed++;
        $display("[TB] FAIL fan_down_%0d: got %0h expected %0h", j, frwrd, ramp_down_exp(16 * n, j));
      end
    end
    finish_move("move_fanfare", FANFARE_ON);
  endtask

  task automatic test_other_opcode();
    bit ok;
    logic [3:0] op;
    for (int r = 0; r < 2; r++) begin
      do op = 4'($urandom_range(0, 15)); while (op == 4'b0010 || op == 4'b0100 || op == 4'b0101);
      issue_cmd({op, 12'($urandom)}, ok);
      tests_run++;
      if (!ok || strt_cal !== 1'b0 || moving !== 1'b0 || send_resp !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL other_ack_%0h: got ack=%0d strt=%b moving=%b resp=%b expected 1 0 0 0", op, ok, strt_cal, moving, send_resp);
      end
      tick();
      tests_run++;
      if (send_resp !== 1'b1 || frwrd !== 10'h000 || desired_heading !== 12'h7FF || fanfare !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL other_resp_%0h: got resp=%b frwrd=%0h dh=%0h fan=%b expected 1 0 7ff 0", op, send_resp, frwrd, desired_heading, fanfare);
      end
      tick();
      tests_run++;
      if ({send_resp, moving} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL other_idle_%0h: got %b expected 00", op, {send_resp, moving});
      end
    end
  endtask

  task automatic test_zero_squares();
    bit ok;
    issue_cmd(16'h4AB0, ok);
    hdg_pulse(12'hABF + 12'h040);
    tests_run++;
    if (!ok || desired_heading !== 12'hABF || send_resp !== 1'b0 || moving !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zero_sq_wait: got ack=%0d dh=%0h resp=%b moving=%b expected 1 abf 0 1", ok, desired_heading, send_resp, moving);
    end
    hdg_pulse(near(12'hABF));
    tests_run++;
    if (send_resp !== 1'b1 || moving !== 1'b0 || frwrd !== 10'h000) begin
      tests_failed++;
      $display("[TB] FAIL zero_sq_done: got resp=%b moving=%b frwrd=%0h expected 1 0 0", send_resp, moving, frwrd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    int a0;
    issue_cmd(16'h4001, ok);
    hdg_pulse(near(12'h000));
    repeat (4) hdg_pulse(near(12'h000));
    a0 = ack_count;
    cmd = 16'h9000;
    cmd_rdy = 1'b1;
    repeat (3) begin
      gap();
      hdg_pulse(near(12'h000));
    end
    tests_run++;
    if (!ok || frwrd !== 10'h070) begin
      tests_failed++;
      $display("[TB] FAIL b2b_speed: got ack=%0d frwrd=%0h expected 1 70", ok, frwrd);
    end
    ir_edge();
    ir_edge();
    repeat (4) hdg_pulse(near(12'h000));
    finish_move("b2b_move", 1'b0);
    tests_run++;
    if (ack_count != a0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_no_ack_busy: got %0d acks expected %0d", ack_count, a0);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (clr_cmd_rdy) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    cmd_rdy = 1'b0;
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ack: got no acknowledge expected one");
    end
    tick();
    tests_run++;
    if (send_resp !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_resp: got %b expected 1", send_resp);
    end
    repeat (3) tick();
    tests_run++;
    if (ack_count != a0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_single_ack: got %0d acks expected %0d", ack_count, a0 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_cal();
    test_move_basic();
    test_reset_midmove();
    test_move_fanfare();
    test_other_opcode();
    test_zero_squares();
    test_back_to_back();
    tests_run++;
    if (overlap_count != 0) begin
      tests_failed++;
      $display("[TB] FAIL ack_resp_overlap: got %0d cycles expected 0", overlap_count);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
